// File: rtl/uio_prbs_checker_if.sv
// User-I/O response port bundle: valid/data toward the consumer, almost-full back to the source.
interface uio_prbs_checker_if #(
   parameter int UIO_PORTS_WIDTH = 128
) ();
   logic                       uio_rs_vld;
   logic [UIO_PORTS_WIDTH-1:0] uio_rs_data;
   logic                       uio_rs_afull;

   modport master (output uio_rs_vld, output uio_rs_data, input uio_rs_afull);
   modport slave  (input uio_rs_vld, input uio_rs_data, output uio_rs_afull);
endinterface

// File: rtl/uio_prbs_checker.sv
// Self-synchronising PRBS31 checker on a user-I/O response port, with saturating
// word/error/lock-loss statistics. Two pipeline stages: capture, then compare/update.
module uio_prbs_checker #(
   parameter int UIO_PORTS_WIDTH = 128,
   parameter int CNT_W           = 48,
   parameter int LOCK_WORDS      = 4,
   parameter int LOSS_WORDS      = 4
) (
   input  logic             clk_per,
   input  logic             reset_per,
   input  logic             i_enable,
   input  logic             i_clear,
   uio_prbs_checker_if.slave uio_rs,
   output logic [1:0]       o_state,
   output logic             o_locked,
   output logic [CNT_W-1:0] o_word_cnt,
   output logic [CNT_W-1:0] o_err_word_cnt,
   output logic [CNT_W-1:0] o_bit_err_cnt,
   output logic [CNT_W-1:0] o_lock_loss_cnt
);

   localparam int W   = UIO_PORTS_WIDTH;
   localparam int PW  = $clog2(W + 1);
   localparam int SW  = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam int LCW = $clog2(LOCK_WORDS + 1);
   localparam int LSW = $clog2(LOSS_WORDS + 1);
   localparam logic [LCW-1:0]   LOCK_M1 = LCW'(LOCK_WORDS - 1);
   localparam logic [LSW-1:0]   LOSS_M1 = LSW'(LOSS_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEEK   = 2'd1,
      S_VERIFY = 2'd2,
      S_LOCKED = 2'd3
   } state_t;

   // Unrolled PRBS31: h[30] is the newest stream bit, h[0] the oldest.
   function automatic logic [W-1:0] prbs_word(input logic [30:0] h);
      logic [W+30:0] x;
      x = '0;
      x[30:0] = h;
      for (int j = 0; j < W; j++) x[31+j] = x[j] ^ x[j+3];
      return x[W+30:31];
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PW-1:0] b);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      if (s > SW'(CNT_MAX)) return CNT_MAX;
      return s[CNT_W-1:0];
   endfunction

   logic             vld_p1_q;
   logic [W-1:0]     data_p1_q;
   state_t           state_q, state_d;
   logic [30:0]      h_q, h_d;
   logic [LCW-1:0]   clean_q, clean_d;
   logic [LSW-1:0]   lerr_q, lerr_d;
   logic             afull_q;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0] err_word_cnt_q, err_word_cnt_d;
   logic [CNT_W-1:0] bit_err_cnt_q, bit_err_cnt_d;
   logic [CNT_W-1:0] lock_loss_cnt_q, lock_loss_cnt_d;

   logic [W-1:0]  exp_word;
   logic [W-1:0]  diff;
   logic [PW-1:0] pop;
   logic          word_err;
   logic          lock_lost;

   // ---- stage 1: capture the response word ----
   always_ff @(posedge clk_per) begin
      data_p1_q <= uio_rs.uio_rs_data;
   end

   // ---- stage 2: compare against expected, update FSM/history/counters ----
   always_comb begin
      exp_word = prbs_word(h_q);
      diff     = data_p1_q ^ exp_word;
      word_err = |diff;
      pop      = '0;
      for (int j = 0; j < W; j++) pop = pop + PW'(diff[j]);
   end

   always_ff @(posedge clk_per) begin
      if (reset_per) begin
         vld_p1_q        <= 1'b0;
         state_q         <= S_IDLE;
         h_q             <= '0;
         clean_q         <= '0;
         lerr_q          <= '0;
         afull_q         <= 1'b1;
         word_cnt_q      <= '0;
         err_word_cnt_q  <= '0;
         bit_err_cnt_q   <= '0;
         lock_loss_cnt_q <= '0;
      end else begin
         vld_p1_q        <= uio_rs.uio_rs_vld;
         state_q         <= state_d;
         h_q             <= h_d;
         clean_q         <= clean_d;
         lerr_q          <= lerr_d;
         afull_q         <= (state_q == S_IDLE);
         word_cnt_q      <= word_cnt_d;
         err_word_cnt_q  <= err_word_cnt_d;
         bit_err_cnt_q   <= bit_err_cnt_d;
         lock_loss_cnt_q <= lock_loss_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      clean_d   = clean_q;
      lerr_d    = lerr_q;
      lock_lost = 1'b0;
      if (!i_enable) begin
         state_d = S_IDLE;
         clean_d = '0;
         lerr_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_SEEK;
            S_SEEK: if (vld_p1_q) begin
               h_d = data_p1_q[W-1 -: 31];
               if (|data_p1_q[W-1 -: 31]) begin
                  state_d = S_VERIFY;
                  clean_d = '0;
               end
            end
            S_VERIFY: if (vld_p1_q) begin
               h_d = exp_word[W-1 -: 31];
               if (word_err) begin
                  state_d = S_SEEK;
               end else if (clean_q == LOCK_M1) begin
                  state_d = S_LOCKED;
                  lerr_d  = '0;
               end else begin
                  clean_d = clean_q + 1'b1;
               end
            end
            S_LOCKED: if (vld_p1_q) begin
               // Received data never feeds the history here, so bit errors cannot propagate.
               h_d = exp_word[W-1 -: 31];
               if (!word_err) begin
                  lerr_d = '0;
               end else if (lerr_q == LOSS_M1) begin
                  state_d   = S_SEEK;
                  lerr_d    = '0;
                  lock_lost = 1'b1;
               end else begin
                  lerr_d = lerr_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      word_cnt_d      = word_cnt_q;
      err_word_cnt_d  = err_word_cnt_q;
      bit_err_cnt_d   = bit_err_cnt_q;
      lock_loss_cnt_d = lock_loss_cnt_q;
      if (i_clear) begin
         word_cnt_d      = '0;
         err_word_cnt_d  = '0;
         bit_err_cnt_d   = '0;
         lock_loss_cnt_d = '0;
      end else if (i_enable && vld_p1_q && (state_q != S_IDLE)) begin
         word_cnt_d = sat_add(word_cnt_q, PW'(1));
         if ((state_q == S_LOCKED) && word_err) begin
            err_word_cnt_d = sat_add(err_word_cnt_q, PW'(1));
            bit_err_cnt_d  = sat_add(bit_err_cnt_q, pop);
         end
         if (lock_lost) lock_loss_cnt_d = sat_add(lock_loss_cnt_q, PW'(1));
      end
   end

   always_comb begin
      o_state             = state_q;
      o_locked            = (state_q == S_LOCKED);
      uio_rs.uio_rs_afull = afull_q;
      o_word_cnt          = word_cnt_q;
      o_err_word_cnt      = err_word_cnt_q;
      o_bit_err_cnt       = bit_err_cnt_q;
      o_lock_loss_cnt     = lock_loss_cnt_q;
   end

endmodule
